// File: rtl/axi4_lite_register_master.sv
// axi4_lite_register_master
//   Single-outstanding AXI4-Lite initiator. A command accepted on the
//   cmd_* handshake becomes one AXI4-Lite write (AW + W, then B) or read
//   (AR, then R). The result is presented on the rsp_* handshake and held
//   until rsp_ready. Responses therefore return in command order.
//
// Parameters
//   N  : data bus width in bytes (4 or 8)
//   A  : address width
//   CW : width of the per-transaction latency counter (saturating)
//
// Ports
//   aclk, areset                      clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb  command request side
//   rsp_valid/ready/write/rdata/resp/cycles response side
//   aw*, w*, b*                       AXI4-Lite write channels
//   ar*, r*                           AXI4-Lite read channels
module axi4_lite_register_master #(
  parameter int N  = 8,
  parameter int A  = 32,
  parameter int CW = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [A-1:0]     cmd_addr,
  input  logic [8*N-1:0]   cmd_wdata,
  input  logic [N-1:0]     cmd_wstrb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [8*N-1:0]   rsp_rdata,
  output logic [1:0]       rsp_resp,
  output logic [CW-1:0]    rsp_cycles,
  output logic [A-1:0]     awaddr,
  output logic [2:0]       awprot,
  output logic             awvalid,
  input  logic             awready,
  output logic [8*N-1:0]   wdata,
  output logic [N-1:0]     wstrb,
  output logic             wvalid,
  input  logic             wready,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready,
  output logic [A-1:0]     araddr,
  output logic [2:0]       arprot,
  output logic             arvalid,
  input  logic             arready,
  input  logic [8*N-1:0]   rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready
);

  if (N != 4 && N != 8) begin : g_bad_n
    $fatal(1, "axi4_lite_register_master: N must be 4 or 8");
  end

  // Clears the byte-lane bits so the address is aligned to the bus width.
  localparam logic [A-1:0] ALIGN_MASK = ~(A'(N - 1));

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WB   = 3'd2,
    RA   = 3'd3,
    RD   = 3'd4,
    RSP  = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            aw_done;
  logic            w_done;
  logic [A-1:0]    addr;

  logic            aw_hs;
  logic            w_hs;
  logic            b_hs;
  logic            r_hs;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign awprot = 3'b000;
  assign arprot = 3'b000;
  assign awaddr = addr;
  assign araddr = addr;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign r_hs  = rvalid & rready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Valids/readies decode directly from state so that an asynchronous
  // reset drops them in the same instant.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_write ? WR : RA;
      end
      WR: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        // AW and W complete independently, possibly in the same cycle.
        if ((aw_done | (awready & ~aw_done)) && (w_done | (wready & ~w_done)))
          state_nxt = WB;
      end
      WB: begin
        bready = 1'b1;
        if (bvalid) state_nxt = RSP;
      end
      RA: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD;
      end
      RD: begin
        rready = 1'b1;
        if (rvalid) state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr       <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_resp   <= 2'b00;
      rsp_cycles <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        addr       <= cmd_addr & ALIGN_MASK;
        wdata      <= cmd_wdata;
        wstrb      <= cmd_wstrb;
        rsp_write  <= cmd_write;
        rsp_rdata  <= '0;
        rsp_resp   <= 2'b00;
        rsp_cycles <= '0;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      // Counts every cycle after accept up to and including the B/R handshake.
      if (state == WR || state == WB || state == RA || state == RD)
        rsp_cycles <= sat_inc(rsp_cycles);
      if (b_hs) rsp_resp <= bresp;
      if (r_hs) begin
        rsp_rdata <= rdata;
        rsp_resp  <= rresp;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_register_master.sv
module tb_axi4_lite_register_master;
  localparam int N  = 8;
  localparam int A  = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            aclk = 1'b0;
  logic            areset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [A-1:0]    cmd_addr;
  logic [63:0]     cmd_wdata;
  logic [7:0]      cmd_wstrb;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_write;
  logic [63:0]     rsp_rdata;
  logic [1:0]      rsp_resp;
  logic [CW-1:0]   rsp_cycles;
  logic [A-1:0]    awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [A-1:0]    araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  int tests = 0;
  int fails = 0;

  axi4_lite_register_master #(.N(N), .A(A), .CW(CW)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected latency count: cycles from accept to the B/R handshake, clipped.
  function automatic int exp_cycles(input int c);
    return (c > CMAX) ? CMAX : c;
  endfunction

  task automatic scramble_cmd(input int hold);
    cmd_valid = hold[0];
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = {$urandom, $urandom};
    cmd_wstrb = 8'($urandom);
  endtask

  task automatic hold_rsp(input int rsp_wait, input logic wr, input logic [63:0] rd,
                          input logic [1:0] rs, input int cyc);
    for (int j = 0; j <= rsp_wait; j++) begin
      rsp_ready = (j == rsp_wait);
      chk("rsp_valid", 64'(rsp_valid), 64'(1));
      chk("rsp_write", 64'(rsp_write), 64'(wr));
      chk("rsp_rdata", rsp_rdata, rd);
      chk("rsp_resp", 64'(rsp_resp), 64'(rs));
      chk("rsp_cycles", 64'(rsp_cycles), 64'(exp_cycles(cyc)));
      chk("rsp_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rsp_bready_rready", 64'({bready, rready}), 64'(0));
      @(negedge aclk);
    end
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("post_rsp_cmd_ready", 64'(cmd_ready), 64'(1));
  endtask

  // Slave timing is given as the cycle index (1 = first cycle after accept)
  // on which each ready/valid is offered for exactly one cycle.
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int aw_at, input int w_at, input int b_at,
                          input logic [1:0] br, input int hold, input int rsp_wait);
    int hs;
    hs = (aw_at > w_at) ? aw_at : w_at;
    chk("wr_accept_ready", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge aclk);
    scramble_cmd(hold);
    for (int k = 1; k <= b_at; k++) begin
      awready = (k == aw_at);
      wready  = (k == w_at);
      bvalid  = (k == b_at);
      bresp   = (k == b_at) ? br : 2'($urandom);
      chk("wr_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("wr_awvalid", 64'(awvalid), 64'(k <= aw_at));
      chk("wr_wvalid", 64'(wvalid), 64'(k <= w_at));
      chk("wr_bready", 64'(bready), 64'(k > hs));
      chk("wr_arvalid", 64'(arvalid), 64'(0));
      if (k <= aw_at) chk("wr_awaddr", 64'(awaddr), 64'(a & ~32'h7));
      if (k <= w_at) begin
        chk("wr_wdata", wdata, d);
        chk("wr_wstrb", 64'(wstrb), 64'(s));
      end
      @(negedge aclk);
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    hold_rsp(rsp_wait, 1'b1, 64'h0, br, b_at);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [63:0] d,
                         input int ar_at, input int r_at, input logic [1:0] rr,
                         input int hold, input int rsp_wait);
    chk("rd_accept_ready", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_wdata = {$urandom, $urandom};
    cmd_wstrb = 8'($urandom);
    @(negedge aclk);
    scramble_cmd(hold);
    for (int k = 1; k <= r_at; k++) begin
      arready = (k == ar_at);
      rvalid  = (k == r_at);
      rdata   = (k == r_at) ? d : {$urandom, $urandom};
      rresp   = (k == r_at) ? rr : 2'($urandom);
      chk("rd_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rd_arvalid", 64'(arvalid), 64'(k <= ar_at));
      chk("rd_rready", 64'(rready), 64'(k > ar_at));
      chk("rd_aw_w_valid", 64'({awvalid, wvalid}), 64'(0));
      if (k <= ar_at) chk("rd_araddr", 64'(araddr), 64'(a & ~32'h7));
      @(negedge aclk);
    end
    arready = 1'b0; rvalid = 1'b0;
    hold_rsp(rsp_wait, 1'b0, d, rr, r_at);
  endtask

  initial begin
    int aw_at, w_at, b_at, ar_at, r_at, hold;
    areset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    repeat (2) @(negedge aclk);

    // Reset state
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'(0));
    chk("rst_awaddr", 64'(awaddr), 64'(0));
    chk("rst_araddr", 64'(araddr), 64'(0));
    chk("rst_wdata", wdata, 64'(0));
    chk("rst_wstrb", 64'(wstrb), 64'(0));
    chk("rst_rsp_rdata", rsp_rdata, 64'(0));
    chk("rst_rsp_misc", 64'({rsp_write, rsp_resp, rsp_cycles}), 64'(0));
    chk("rst_prot", 64'({awprot, arprot}), 64'(0));
    areset = 1'b0;
    @(negedge aclk);

    // Directed: aligned write, same-cycle AW/W, B next cycle
    do_write(32'h1007, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1, 1, 2, 2'b00, 0, 0);
    // Directed: W leads AW by 3 cycles, B 2 cycles after AW
    do_write(32'h2004, 64'h1111_2222_3333_4444, 8'h0F, 4, 1, 6, 2'b00, 0, 1);
    // Directed: read with SLVERR, response held 5 cycles
    do_read(32'h20, 64'h0123456789ABCDEF, 2, 6, 2'b10, 0, 5);
    // Directed: back-to-back with cmd_valid held high
    do_write(32'h40, 64'hA5A5_5A5A_0F0F_F0F0, 8'h3C, 2, 3, 4, 2'b11, 1, 0);
    do_read(32'h48, 64'hFEED_FACE_0BAD_F00D, 1, 2, 2'b00, 0, 0);
    // Directed: latency counter saturation
    do_write(32'h80, 64'h0, 8'h01, 1, 1, 22, 2'b00, 0, 0);

    // Directed: reset while in RD
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100;
    @(negedge aclk);
    cmd_valid = 1'b0; arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    chk("pre_rst_rready", 64'(rready), 64'(1));
    areset = 1'b1;
    #1;
    chk("mid_rst_rready", 64'(rready), 64'(0));
    chk("mid_rst_arvalid", 64'(arvalid), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    do_read(32'h10C, 64'h7766_5544_3322_1100, 1, 3, 2'b01, 0, 0);

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      hold = (i < 23) ? int'($urandom_range(0, 1)) : 0;
      if ($urandom_range(0, 1) == 1) begin
        aw_at = $urandom_range(1, 4);
        w_at  = $urandom_range(1, 4);
        b_at  = ((aw_at > w_at) ? aw_at : w_at) + int'($urandom_range(1, 14));
        do_write($urandom, {$urandom, $urandom}, 8'($urandom), aw_at, w_at, b_at,
                 2'($urandom), hold, $urandom_range(0, 3));
      end else begin
        ar_at = $urandom_range(1, 4);
        r_at  = ar_at + int'($urandom_range(1, 14));
        do_read($urandom, {$urandom, $urandom}, ar_at, r_at, 2'($urandom),
                hold, $urandom_range(0, 3));
      end
    end
    cmd_valid = 1'b0;
    @(negedge aclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_lite_register_master.md
Name: axi4_lite_register_master

Overview:
Single-outstanding AXI4-Lite initiator. It converts a simple command/response handshake into AXI4-Lite read and write transactions. It is the initiator counterpart to the register-file slave side: it lets sequencers, debug bridges and test logic read and write register banks over AXI4-Lite. Only one transaction is in flight at a time, and responses return in command order.

Parameters:
N, 8, data bus width in bytes; only 4 or 8 legal (simulation $fatal otherwise)
A, 32, address width
CW, 16, width of the per-transaction latency counter

Ports:
aclk  input  1  clock; all logic on rising edge
areset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  A  byte address
cmd_wdata  input  8*N  write data
cmd_wstrb  input  N  write byte strobes
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_write  output  1  echo of cmd_write
rsp_rdata  output  8*N  read data; 0 for writes
rsp_resp  output  2  BRESP or RRESP
rsp_cycles  output  CW  cycles from command accept to AXI response handshake, saturating
awaddr  output  A  write address
awprot  output  3  constant 3'b000
awvalid  output  1
awready  input  1
wdata  output  8*N
wstrb  output  N
wvalid  output  1
wready  input  1
bresp  input  2
bvalid  input  1
bready  output  1
araddr  output  A  read address
arprot  output  3  constant 3'b000
arvalid  output  1
arready  input  1
rdata  input  8*N
rresp  input  2
rvalid  input  1
rready  output  1

Behaviour:
- Reset (async assert, sync release): state IDLE. All valid/ready outputs 0 except cmd_ready=1. All address, data, strobe and rsp_* outputs 0.
- IDLE: cmd_ready=1. On accept, register the command. Address is registered with its low log2(N) bits forced to 0. Counter cleared to 0.
  - Write: go to WR; awvalid=1 and wvalid=1 from the next cycle.
  - Read: go to RA; arvalid=1 from the next cycle.
- cmd_ready=0 in every state except IDLE.
- WR: awvalid and wvalid deassert independently, the cycle after their own handshake. They may complete in either order or in the same cycle. Address, data and strobes stay stable while the matching valid is high. When both are done, go to WB with bready=1.
- WB: on bvalid & bready, capture bresp, set bready=0, go to RSP.
- RA: on arvalid & arready, set arvalid=0 and rready=1, go to RD.
- RD: on rvalid & rready, capture rdata and rresp, set rready=0, go to RSP.
- AXI outputs never drop a valid without a handshake. There is no timeout and no abort.
- rsp_cycles increments every cycle from the cycle after command accept through the B or R handshake cycle inclusive. It saturates at 2^CW-1 and never wraps. Minimum write value is 2 (AW/W handshake in the first cycle, B in the next). Minimum read value is 2.
- RSP: rsp_valid=1; rsp_* held stable until rsp_ready. On handshake go to IDLE, with cmd_ready=1 the next cycle. Back-to-back throughput is therefore at most one command per (AXI latency + 2) cycles.
- rsp_rdata=0 for writes.
- SLVERR/DECERR responses are passed through unchanged; the block takes no other action.
- Reset mid-transaction: all valids and readies drop immediately (asynchronous). The pending command and response are discarded.
- Input cmd_* fields are ignored outside the accept cycle.

Test Plan:
- Write, N=8: cmd_addr=0x1007, wdata=0xDEADBEEF_CAFEF00D, wstrb=0xFF; slave gives awready and wready the same cycle, bvalid the next cycle with OKAY -> awaddr=0x1000, rsp_write=1, rsp_resp=0, rsp_cycles=2.
- Write with skew: wready 3 cycles before awready; bvalid 2 cycles after awready -> wvalid drops after its handshake while awvalid stays high; data stable; single B accepted.
- Read: addr=0x20; arready after 1 wait cycle; rvalid after 4 cycles with rdata=0x0123456789ABCDEF and rresp=2'b10 -> rsp_rdata=0x0123456789ABCDEF, rsp_resp=2, rsp_ready held low for 5 cycles with rsp_* stable.
- Back-to-back commands with cmd_valid held high: cmd_ready low until the previous response handshake; the second command is accepted the cycle after.
- Saturation with CW=4: bvalid delayed 20 cycles -> rsp_cycles=15.
- areset pulsed while in RD with rready=1 -> rready, arvalid and rsp_valid are 0 immediately; cmd_ready=1 after release; a following read completes normally.
